// File: rtl/inst_rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM loader.
// Holds FSM encodings, the default depth and the tail-word packer.
package inst_rom_loader_pkg;

  localparam int RomAddrW = 10;
  localparam logic [31:0] ZeroWord = 32'h0;

  typedef enum logic [1:0] {
    RomIdle = 2'd0,
    RomLoad = 2'd1,
    RomRun  = 2'd2
  } rom_state_e;

  // Left-justify n+1 bytes (n = bytes already shifted in), zero-pad the rest.
  function automatic logic [31:0] pack_word(
    input logic [31:0] sh,
    input logic [7:0]  b,
    input logic [1:0]  n
  );
    logic [31:0] w;
    unique case (n)
      2'd0:    w = {b, 24'h0};
      2'd1:    w = {sh[7:0], b, 16'h0};
      2'd2:    w = {sh[15:0], b, 8'h0};
      default: w = {sh[23:0], b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_rom_loader_array.sv
// Instruction storage: one synchronous write port, one async read port.
// The array is never reset.
module inst_rom_loader_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch responder that fills its ROM from a byte-serial loader port
// and stalls the core until a full image is resident.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = RomAddrW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_i,
  input  logic [31:0]     addr_i,
  output logic [31:0]     inst_o,
  input  logic            load_start_i,
  input  logic            load_valid_i,
  input  logic [7:0]      load_byte_i,
  input  logic            load_last_i,
  output logic            load_ready_o,
  output logic            stallreq_o,
  output logic            loaded_o,
  output logic            overflow_o,
  output logic [ADDR_W:0] words_o
);

  localparam logic [ADDR_W:0] Full = (ADDR_W+1)'(2**ADDR_W);

  rom_state_e      state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            commit;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            in_range;
  logic            unused_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RomIdle;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ovf_d    = ovf_q;
    commit   = 1'b0;
    we       = 1'b0;
    wdata    = pack_word(shift_q, load_byte_i, cnt_q);
    accept   = (state_q == RomLoad) && load_valid_i
               && !load_start_i;

    if (load_start_i) begin
      state_d  = RomLoad;
      wr_ptr_d = '0;
      cnt_d    = '0;
      shift_d  = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      shift_d = {shift_q[23:0], load_byte_i};
      cnt_d   = cnt_q + 2'd1;
      commit  = (cnt_q == 2'd3) || load_last_i;
      if (load_last_i) begin
        state_d = RomRun;
        cnt_d   = '0;
        shift_d = '0;
      end
    end

    // Past the end of storage, complete words are dropped and flagged.
    if (commit) begin
      if (wr_ptr_q == Full) begin
        ovf_d = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  inst_rom_loader_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (addr_i[ADDR_W+1:2]),
    .rdata_o (rdata)
  );

  assign in_range     = (addr_i[31:ADDR_W+2] == '0);
  assign unused_addr  = ^addr_i[1:0];

  assign load_ready_o = (state_q == RomLoad);
  assign stallreq_o   = (state_q != RomRun);
  assign loaded_o     = (state_q == RomRun);
  assign overflow_o   = ovf_q;
  assign words_o      = wr_ptr_q;

  assign inst_o = (loaded_o && ce_i && in_range) ? rdata : ZeroWord;

endmodule
